// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path: FSM states,
// opcode constants, ALUOP codes and datapath mux select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALUOP_ADD     = 3'b000;
  localparam logic [2:0] ALUOP_SUB     = 3'b001;
  localparam logic [2:0] ALUOP_CMP     = 3'b100;
  localparam logic [2:0] ALUOP_SPECIAL = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state-to-control decode; only mem_ready/zero gate the
// strobes, and reset forces FETCH selects with every enable off.
module ctrl_out_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_reset,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output logic       o_mem_req,
  output logic       o_pc_write,
  output logic       o_ir_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [2:0] o_aluop,
  output logic       o_illegal
);

  state_t w_state;

  always_comb begin
    o_mem_req    = 1'b0;
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = '0;
    o_alu_src_b  = '0;
    o_result_src = '0;
    o_aluop      = ALUOP_ADD;
    o_illegal    = 1'b0;
    // Reset overrides the registered state so a stalled store cannot strobe.
    w_state      = i_reset ? S_FETCH : state_t'(i_state);

    case (w_state)
      S_FETCH: begin
        o_mem_req    = 1'b1;
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALU;
      end
      S_DECODE: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_result_src = RES_MEM;
        o_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_mem_req   = 1'b1;
        o_adr_src   = 1'b1;
        o_mem_write = i_mem_ready;
      end
      S_EXECR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_RS2;
        o_aluop     = ALUOP_SPECIAL;
      end
      S_EXECI: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        o_aluop     = ALUOP_SPECIAL;
      end
      S_ALUWB: begin
        o_result_src = RES_ALUOUT;
        o_reg_write  = 1'b1;
      end
      S_BEQ: begin
        o_alu_src_a  = SRCA_RS1;
        o_alu_src_b  = SRCB_RS2;
        o_aluop      = ALUOP_SUB;
        o_result_src = RES_ALUOUT;
        o_pc_write   = i_zero;
      end
      S_JAL: begin
        o_alu_src_a  = SRCA_OLDPC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALUOUT;
        o_pc_write   = 1'b1;
      end
      S_ILLEGAL: o_illegal = 1'b1;
      default: ;
    endcase

    if (i_reset) begin
      o_mem_req  = 1'b0;
      o_ir_write = 1'b0;
      o_pc_write = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: state register plus next-state logic;
// output decode lives in ctrl_out_decode.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] ALUOP,
  output logic       illegal
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BEQ;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  ctrl_out_decode u_decode (
    .i_state      (r_state),
    .i_reset      (reset),
    .i_mem_ready  (mem_ready),
    .i_zero       (zero),
    .o_mem_req    (mem_req),
    .o_pc_write   (pc_write),
    .o_ir_write   (ir_write),
    .o_adr_src    (adr_src),
    .o_mem_write  (mem_write),
    .o_reg_write  (reg_write),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_result_src (result_src),
    .o_aluop      (ALUOP),
    .o_illegal    (illegal)
  );

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: opcode  in  7  instr[6:0] from instruction register.
REQ-004 SHALL have port: zero  in  1  ALU zero flag.
REQ-005 SHALL have port: mem_ready  in  1  memory access completes this cycle.
REQ-006 SHALL have port: mem_req  out  1  memory access request.
REQ-007 SHALL have port: pc_write  out  1  PC load enable.
REQ-008 SHALL have port: ir_write  out  1  instruction register load enable.
REQ-009 SHALL have port: adr_src  out  1  0 = PC, 1 = ALU result as memory address.
REQ-010 SHALL have port: mem_write  out  1  store strobe.
REQ-011 SHALL have port: reg_write  out  1  register file write enable.
REQ-012 SHALL have port: alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1.
REQ-013 SHALL have port: alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
REQ-014 SHALL have port: result_src  out  2  00 ALU out register, 01 memory data, 10 ALU result.
REQ-015 SHALL have port: ALUOP  out  3  operation class for the ALU decoder.
REQ-016 SHALL have port: illegal  out  1  sticky illegal-opcode flag.

Function
REQ-017 SHALL be a Moore FSM; every output is a combinational function of state only, except mem_req, pc_write and mem_write, which are also gated by mem_ready or zero as stated below.
REQ-018 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
REQ-019 SHALL drive ALUOP with these codes: 000 ADD, 001 SUB, 100 COMPARE, 111 SPECIAL (funct3-decoded).
REQ-020 FETCH SHALL drive the following:
- mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ALUOP=000, result_src=10.
- ir_write and pc_write equal to mem_ready.
- It SHALL remain in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-021 DECODE SHALL drive alu_src_a=01, alu_src_b=01, ALUOP=000 (branch target) and dispatch on opcode:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- any other value -> ILLEGAL.
REQ-022 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, ALUOP=000, then go to MEMREAD for opcode 0000011 and to MEMWRITE otherwise.
REQ-023 MEMREAD SHALL drive mem_req=1 and adr_src=1, hold until mem_ready=1, then go to MEMWB.
REQ-024 MEMWB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-025 MEMWRITE SHALL drive mem_req=1, adr_src=1 and mem_write=mem_ready, hold until mem_ready=1, then go to FETCH.
REQ-026 EXECR SHALL drive alu_src_a=10, alu_src_b=00, ALUOP=111, then go to ALUWB.
REQ-027 EXECI SHALL drive alu_src_a=10, alu_src_b=01, ALUOP=111, then go to ALUWB.
REQ-028 ALUWB SHALL drive result_src=00 and reg_write=1, then go to FETCH.
REQ-029 BEQ SHALL drive the following, then go to FETCH:
- alu_src_a=10, alu_src_b=00, ALUOP=001, result_src=00.
- pc_write=zero.
REQ-030 JAL SHALL drive the following, then go to ALUWB:
- alu_src_a=01, alu_src_b=10, ALUOP=000, result_src=00.
- pc_write=1.
REQ-031 ILLEGAL SHALL be terminal until reset, with illegal=1 and every write enable and mem_req held at 0.
REQ-032 Outputs not listed for a state SHALL be 0.
REQ-033 Cycles per instruction with no memory stall SHALL be:
- lw 5.
- sw 4.
- R/I-type 4.
- beq 3.
- jal 4.

Reset
REQ-034 reset=1 at a clock edge SHALL force state FETCH and clear illegal, in any state, including mid-stall.
REQ-035 While reset is asserted, every output SHALL be 0 except the FETCH mux selects, with mem_req=0.
REQ-036 The first mem_req SHALL appear in the first cycle after reset deasserts.

Structure
REQ-037 A shared package riscv_ctrl_pkg SHALL hold:
- the state enumeration (4 bits);
- the opcode constants;
- the ALUOP codes, shared with the ALU decoder.
REQ-038 The block SHALL consist of a next-state register plus one sub-module, ctrl_out_decode, which maps state to outputs combinationally.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Reset, then addi 0x00A00093 with mem_ready=1: states FETCH, DECODE, EXECI, ALUWB, FETCH; reg_write high only in cycle 4; ALUOP=111 in cycle 3.
- lw 0x0000A103 with mem_ready=0 for the first 2 MEMREAD cycles: MEMREAD lasts 3 cycles; MEMWB has result_src=01; total 7 cycles.
- beq 0x00208463: zero=1 gives pc_write=1 in the BEQ cycle; zero=0 gives pc_write=0; both return to FETCH after 3 cycles.
- Opcode 0x7F: ILLEGAL entered after DECODE, illegal=1 and no write enables for 10 cycles; reset returns to FETCH with illegal=0.
- reset asserted during a MEMWRITE stall: no mem_write pulse; FETCH on the next cycle.
